// File: rtl/avr_irq_if.sv
// Core-side bus between avr_core and avr_irq_ctrl: IO register
// access plus the interrupt request/acknowledge handshake.
interface avr_irq_if #(
    parameter int VECT_W = 2
);
    logic              io_re;
    logic              io_we;
    logic [5:0]        io_a;
    logic [7:0]        io_wd;
    logic [7:0]        io_rd;
    logic              iflag;
    logic [VECT_W-1:0] ivect;
    logic              ieack_v;
    logic [VECT_W-1:0] ieack;

    modport master (
        output io_re, io_we, io_a, io_wd, ieack_v, ieack,
        input  io_rd, iflag, ivect
    );

    modport slave (
        input  io_re, io_we, io_a, io_wd, ieack_v, ieack,
        output io_rd, iflag, ivect
    );
endinterface

// File: rtl/avr_irq_ctrl.sv
// Fixed-priority interrupt controller for avr_core (IEN/IPEND/ISTAT/IMODE).
// Optional AVR_IRQ_SYNC_EN adds a 2-flop synchroniser on irq_in.
module avr_irq_ctrl #(
    parameter int         CHANNELS = 4,
    parameter int         VECT_W   = 2,
    parameter logic [5:0] IO_BASE  = 6'h38
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] irq_in,
    avr_irq_if.slave            bus
);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

    state_e              state_q;
    logic                iflag_q;
    logic [VECT_W-1:0]   ivect_q;
    logic [CHANNELS-1:0] ien_q, ien_d;
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] hist_q;
    logic [CHANNELS-1:0] irq_s;

`ifdef AVR_IRQ_SYNC_EN
    logic [CHANNELS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    logic sel_ien, sel_pend, sel_stat, sel_mode;

    assign sel_ien  = (bus.io_a == IO_BASE);
    assign sel_pend = (bus.io_a == IO_BASE + 6'd1);
    assign sel_stat = (bus.io_a == IO_BASE + 6'd2);
    assign sel_mode = (bus.io_a == IO_BASE + 6'd3);

    logic                unused_wd;
    assign unused_wd = ^bus.io_wd;

    logic [CHANNELS-1:0] cand, ack_mask, w1c_mask, edge_set;
    logic [VECT_W-1:0]   win;
    logic                held, ack_hit;

    assign cand     = pend_q & ien_q;
    assign edge_set = irq_s & ~hist_q;
    assign ack_hit  = (state_q == REQ) && bus.ieack_v
                      && (bus.ieack == ivect_q);

    // Descending scan so the lowest set index wins.
    always_comb begin
        win      = '0;
        held     = 1'b0;
        ack_mask = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (cand[i])
                win = VECT_W'(i);
            if (ivect_q == VECT_W'(i)) begin
                held        = cand[i];
                ack_mask[i] = ack_hit;
            end
        end
    end

    always_comb begin
        ien_d    = ien_q;
        mode_d   = mode_q;
        w1c_mask = '0;
        if (bus.io_we) begin
            if (sel_ien)
                ien_d = bus.io_wd[CHANNELS-1:0];
            if (sel_mode)
                mode_d = bus.io_wd[CHANNELS-1:0];
            if (sel_pend)
                w1c_mask = bus.io_wd[CHANNELS-1:0];
        end
        // Edge set beats any clear; level bits just track the input.
        pend_d = (mode_q & (edge_set | (pend_q & ~(w1c_mask | ack_mask))))
               | (~mode_q & irq_s);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            iflag_q <= 1'b0;
            ivect_q <= '0;
            ien_q   <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
            hist_q  <= '0;
        end else begin
            ien_q  <= ien_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            hist_q <= irq_s;
            unique case (state_q)
                IDLE: begin
                    iflag_q <= 1'b0;
                    if (|cand) begin
                        ivect_q <= win;
                        iflag_q <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (ack_hit) begin
                        iflag_q <= 1'b0;
                        state_q <= GAP;
                    end else if (!held) begin
                        iflag_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                GAP: begin
                    iflag_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    iflag_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.io_rd = 8'h00;
        if (bus.io_re) begin
            unique case (1'b1)
                sel_ien:  bus.io_rd[CHANNELS-1:0] = ien_q;
                sel_pend: bus.io_rd[CHANNELS-1:0] = pend_q;
                sel_stat: begin
                    bus.io_rd[7]        = iflag_q;
                    bus.io_rd[VECT_W-1:0] = ivect_q;
                end
                sel_mode: bus.io_rd[CHANNELS-1:0] = mode_q;
                default:  bus.io_rd = 8'h00;
            endcase
        end
    end

    assign bus.iflag = iflag_q;
    assign bus.ivect = ivect_q;

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Directed bench for avr_irq_ctrl: reset, handshake, priority,
// level drop, register boundaries and request latency.
module tb_avr_irq_ctrl;

`ifdef AVR_IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam logic [5:0] A_IEN  = 6'h38;
    localparam logic [5:0] A_PEND = 6'h39;
    localparam logic [5:0] A_STAT = 6'h3A;
    localparam logic [5:0] A_MODE = 6'h3B;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] irq_in = 4'h0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] d;
    int         n;

    avr_irq_if #(.VECT_W(2)) bus ();

    avr_irq_ctrl #(
        .CHANNELS(4),
        .VECT_W  (2),
        .IO_BASE (6'h38)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .irq_in(irq_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] v);
        bus.io_re = 1'b1;
        bus.io_a  = a;
        #1;
        v = bus.io_rd;
        bus.io_re = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] v);
        bus.io_we = 1'b1;
        bus.io_a  = a;
        bus.io_wd = v;
        step();
        bus.io_we = 1'b0;
    endtask

    task automatic ack(input logic [1:0] v);
        bus.ieack_v = 1'b1;
        bus.ieack   = v;
        step();
        bus.ieack_v = 1'b0;
    endtask

    initial begin
        bus.io_re   = 1'b0;
        bus.io_we   = 1'b0;
        bus.io_a    = 6'h00;
        bus.io_wd   = 8'h00;
        bus.ieack_v = 1'b0;
        bus.ieack   = 2'd0;

        // Reset with all sources active.
        rst    = 1'b0;
        irq_in = 4'hF;
        step();
        step();
        chk("rst_iflag", {7'd0, bus.iflag}, 8'h00);
        chk("rst_ivect", {6'd0, bus.ivect}, 8'h00);
        chk("rst_iord", bus.io_rd, 8'h00);
        rst    = 1'b1;
        irq_in = 4'h0;
        rd(A_IEN, d);  chk("rst_ien", d, 8'h00);
        rd(A_PEND, d); chk("rst_pend", d, 8'h00);
        rd(A_MODE, d); chk("rst_mode", d, 8'h00);
        repeat (4) step();

        // Edge handshake on channel 2.
        wr(A_MODE, 8'h0F);
        wr(A_IEN, 8'h04);
        rd(A_MODE, d); chk("mode_rw", d, 8'h0F);
        irq_in = 4'h4;
        step();
        irq_in = 4'h0;
        repeat (LAT) step();
        rd(A_PEND, d); chk("edge_pend", d, 8'h04);
        chk("edge_iflag_lo", {7'd0, bus.iflag}, 8'h00);
        step();
        chk("edge_iflag", {7'd0, bus.iflag}, 8'h01);
        chk("edge_ivect", {6'd0, bus.ivect}, 8'h02);
        rd(A_STAT, d); chk("edge_stat", d, 8'h82);
        ack(2'd1);
        chk("badack_iflag", {7'd0, bus.iflag}, 8'h01);
        chk("badack_ivect", {6'd0, bus.ivect}, 8'h02);
        rd(A_PEND, d); chk("badack_pend", d, 8'h04);
        ack(2'd2);
        chk("ack_iflag", {7'd0, bus.iflag}, 8'h00);
        rd(A_PEND, d); chk("ack_pend", d, 8'h00);
        step();
        chk("ack_idle", {7'd0, bus.iflag}, 8'h00);

        // Edge coincident with W1C: set wins, then plain W1C clears.
        wr(A_IEN, 8'h00);
        irq_in = 4'h4;
        repeat (LAT) step();
        wr(A_PEND, 8'h04);
        irq_in = 4'h0;
        rd(A_PEND, d); chk("setbeatsclr", d, 8'h04);
        wr(A_PEND, 8'h04);
        rd(A_PEND, d); chk("w1c", d, 8'h00);

        // Priority: ch3 then ch1; vector 3 held until ack.
        wr(A_IEN, 8'h0F);
        irq_in = 4'h8;
        step();
        irq_in = 4'h2;
        step();
        irq_in = 4'h0;
        repeat (LAT) step();
        chk("prio_iflag", {7'd0, bus.iflag}, 8'h01);
        chk("prio_ivect", {6'd0, bus.ivect}, 8'h03);
        repeat (2) step();
        chk("prio_hold", {6'd0, bus.ivect}, 8'h03);
        rd(A_PEND, d); chk("prio_pend", d, 8'h0A);
        ack(2'd3);
        chk("gap_iflag", {7'd0, bus.iflag}, 8'h00);
        step();
        step();
        chk("next_iflag", {7'd0, bus.iflag}, 8'h01);
        chk("next_ivect", {6'd0, bus.ivect}, 8'h01);
        ack(2'd1);
        rd(A_PEND, d); chk("next_pend", d, 8'h00);

        // Level request released without ack.
        wr(A_MODE, 8'h00);
        wr(A_IEN, 8'h01);
        irq_in = 4'h1;
        repeat (2 + LAT) step();
        chk("lvl_iflag", {7'd0, bus.iflag}, 8'h01);
        chk("lvl_ivect", {6'd0, bus.ivect}, 8'h00);
        wr(A_PEND, 8'h01);
        rd(A_PEND, d); chk("lvl_w1c_noeff", d, 8'h01);
        irq_in = 4'h0;
        repeat (2 + LAT) step();
        chk("lvl_drop", {7'd0, bus.iflag}, 8'h00);
        rd(A_PEND, d); chk("lvl_pend", d, 8'h00);
        rd(A_STAT, d); chk("lvl_stat", d, 8'h00);

        // Window boundaries.
        rd(6'h3C, d); chk("oob_read", d, 8'h00);
        bus.io_a = A_IEN;
        #1;
        chk("no_re", bus.io_rd, 8'h00);
        wr(A_IEN, 8'hFF);
        rd(A_IEN, d); chk("ien_mask", d, 8'h0F);

        // Request latency, then reset mid-REQ.
        wr(A_IEN, 8'h01);
        wr(A_MODE, 8'h01);
        irq_in = 4'h1;
        n = 0;
        while (n < 10 && bus.iflag !== 1'b1) begin
            step();
            n++;
            if (n == 1) irq_in = 4'h0;
        end
        chk("latency", 8'(n), 8'(2 + LAT));
        rst = 1'b0;
        step();
        chk("rst_req", {7'd0, bus.iflag}, 8'h00);
        rst = 1'b1;
        step();
        chk("rst_req_idle", {7'd0, bus.iflag}, 8'h00);
        rd(A_IEN, d); chk("rst_req_ien", d, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
